priv_1_11_ext_int_ctrl: RTL and testbench
=========================================

# priv_1_11_ext_int_ctrl

Platform-level external interrupt controller feeding the machine-mode external interrupt input of the priv 1.11 block through `core_interrupt_if`. It latches rising edges from `NUM_SRC` device interrupt lines, arbitrates by programmable priority against a threshold, and drives `ext_int` / `ext_int_clear`. Software retrieves the winning source with a claim handshake and releases it with a complete handshake. Only one claim may be outstanding at a time.

## Interface
- `NUM_SRC`, 8: number of device interrupt sources. Source `i` (bit `i` of `src_irq`) has ID `i+1`; ID 0 means "none".
- `PRIO_W`, 3: priority width. Priority 0 means never interrupt.
- `ID_W`, `$clog2(NUM_SRC+1)`: claim/complete ID width.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  asynchronous, active-high reset (asserted = 1).
- `src_irq`  in  NUM_SRC  device interrupt lines, level, already synchronous to `CLK`.
- `en_wen`  in  1  write `en_wdata` to the enable register.
- `en_wdata`  in  NUM_SRC  per-source enable.
- `prio_wen`  in  1  write `prio_wdata` to the priority of source `prio_idx`.
- `prio_idx`  in  ID_W  target source ID; writes to 0 or to an ID above NUM_SRC are ignored.
- `prio_wdata`  in  PRIO_W  priority value.
- `thresh_wen`  in  1  write `thresh_wdata` to the threshold register.
- `thresh_wdata`  in  PRIO_W  new threshold.
- `claim_req`  in  1  single-cycle claim strobe.
- `claim_valid`  out  1  one-cycle response pulse to a claim.
- `claim_id`  out  ID_W  claimed ID; valid while `claim_valid` is high.
- `complete_req`  in  1  single-cycle complete strobe.
- `complete_id`  in  ID_W  ID being completed.
- `ext_int`  out  1  to `interrupt_if.ext_int`.
- `ext_int_clear`  out  1  to `interrupt_if.ext_int_clear`; one-cycle pulse.

## Operation
- **Gateway.** `prev_irq` is a registered copy of `src_irq`. A rising edge (`src_irq & ~prev_irq`) sets `pending[i]`. Edges are dropped while source `i` is in service, and dropped on the same edge that claims source `i`.
- **Eligibility.** A source is eligible when it is pending, enabled, and its priority is greater than the threshold (strictly). Priority 0 never qualifies.
- **Arbiter.** Selects the highest priority; ties go to the lowest ID. The result is registered as `best_valid`, `best_id`, `best_prio`, and the register updates every cycle.
- **FSM states: IDLE, ASSERT, SERVICE.**
  - IDLE → ASSERT when `best_valid` = 1.
  - ASSERT → IDLE when `best_valid` = 0, for example after an enable, priority or threshold change. `ext_int_clear` pulses.
  - ASSERT with `claim_req` = 1: `claim_valid` = 1 and `claim_id` = `best_id`. `pending[best_id]` is cleared, `active_id` = `best_id`, and the FSM goes to SERVICE. `ext_int_clear` pulses.
  - SERVICE with `complete_req` = 1 and `complete_id` == `active_id` → IDLE, and the in-service mark is cleared. A mismatched complete is ignored.
  - `claim_req` in IDLE or SERVICE: `claim_valid` = 1, `claim_id` = 0, no state change.
- **Output.** `ext_int` = (state == ASSERT).
- **Configuration writes** take effect on the next edge. A claim always uses the `best_id` registered before the claim edge, even if a configuration write occurs in the same cycle.
- **Reset** (including mid-operation): `pending`, `prev_irq`, enable, all priorities, threshold, `best_*` and `active_id` are all 0. State is IDLE. `ext_int`, `ext_int_clear`, `claim_valid` and `claim_id` are all 0.

## Timing
- Source rise sampled at edge 0: `pending` is set after edge 0, `best_valid` after edge 1, `ext_int` = 1 after edge 2.
- Claim: `claim_req` is sampled at edge k. `claim_valid`, `claim_id` and `ext_int_clear` are high for exactly the cycle after edge k, and `ext_int` = 0 after edge k.
- Complete at edge k: state is IDLE after edge k. Another pending source raises `ext_int` after edge k+1 at the earliest. `best_valid` is already registered, so the earliest is k+1.
- All outputs are registered and there is no combinational path from inputs to outputs.

## Test plan
- **Basic.** Enable all, prio[3] = 5, threshold 0, pulse `src_irq[2]`. Required: `ext_int` = 1 two cycles after the sampling edge. Claim returns `claim_id` = 3 and `ext_int` falls with a one-cycle `ext_int_clear`. Complete with 3 → IDLE.
- **Priority and tie.** prio[2] = 4, prio[5] = 6, prio[7] = 6, fire all three simultaneously. Required: claims in order 5, 7, 2, with a complete between each.
- **Threshold and masking.** prio[4] = 3, threshold 3, fire source 4: `ext_int` stays 0. Set threshold 2: `ext_int` = 1. Disable source 4: ASSERT → IDLE with an `ext_int_clear` pulse.
- **Null and mismatched.** `claim_req` in IDLE → `claim_valid` = 1, `claim_id` = 0. In SERVICE with `active_id` 3, complete with 4 → still SERVICE, and a second claim returns 0.
- **In-service edge drop.** Claim source 1, re-pulse `src_irq[0]` during SERVICE, then complete 1. Required: `ext_int` remains 0 and `pending[0]` = 0.
- **Reset mid-operation.** Assert `nRST` while in SERVICE. Required: all outputs 0 immediately (asynchronously). After release, firing a source produces no `ext_int` until its priority is reprogrammed.

Source files
------------

// File: rtl/priv_1_11_ext_int_ctrl.sv
`default_nettype none
// =============================================================================
// priv_1_11_ext_int_ctrl: edge-latching external interrupt controller with
// priority arbitration, threshold masking and a claim/complete handshake.
// Revision: 1.0
// =============================================================================
module priv_1_11_ext_int_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               en_wen,
  input  logic [NUM_SRC-1:0] en_wdata,
  input  logic               prio_wen,
  input  logic [ID_W-1:0]    prio_idx,
  input  logic [PRIO_W-1:0]  prio_wdata,
  input  logic               thresh_wen,
  input  logic [PRIO_W-1:0]  thresh_wdata,
  input  logic               claim_req,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete_req,
  input  logic [ID_W-1:0]    complete_id,
  output logic               ext_int,
  output logic               ext_int_clear
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [NUM_SRC-1:0]      prev_irq, pending, pending_nxt, enable;
  logic [PRIO_W-1:0]       prio [NUM_SRC];
  logic [PRIO_W-1:0]       thresh;
  logic                    best_valid;
  logic [ID_W-1:0]         best_id;
  logic [ID_W-1:0]         active_id, active_nxt;
  logic                    claim_take, claim_valid_nxt, ext_int_clear_nxt;
  logic [ID_W-1:0]         claim_id_nxt;
  logic [NUM_SRC-1:0]      eligible, claim_mask, service_mask;
  logic                    arb_valid;
  logic [ID_W-1:0]         arb_id;
  logic [PRIO_W-1:0]       arb_prio;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    localparam logic [ID_W-1:0] SRC_ID = ID_W'(g + 1);
    assign eligible[g]     = pending[g] && enable[g] && (prio[g] > thresh);
    assign claim_mask[g]   = claim_take && (best_id == SRC_ID);
    assign service_mask[g] = (state == SERVICE) && (active_id == SRC_ID);
  end

  // Ascending scan with strict compare keeps the lowest ID on a priority tie.
  always_comb begin
    arb_valid = 1'b0;
    arb_id    = '0;
    arb_prio  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!arb_valid || (prio[i] > arb_prio))) begin
        arb_valid = 1'b1;
        arb_id    = ID_W'(i + 1);
        arb_prio  = prio[i];
      end
    end
  end

  // Edges for the in-service source and the source being claimed are dropped.
  assign pending_nxt = (pending | (src_irq & ~prev_irq & ~service_mask)) & ~claim_mask;

  always_comb begin
    state_nxt         = state;
    active_nxt        = active_id;
    claim_take        = 1'b0;
    claim_valid_nxt   = claim_req;
    claim_id_nxt      = '0;
    ext_int_clear_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (best_valid) state_nxt = ASSERT;
      end
      ASSERT: begin
        if (claim_req && best_valid) begin
          claim_take        = 1'b1;
          claim_id_nxt      = best_id;
          active_nxt        = best_id;
          state_nxt         = SERVICE;
          ext_int_clear_nxt = 1'b1;
        end else if (!best_valid) begin
          state_nxt         = IDLE;
          ext_int_clear_nxt = 1'b1;
        end
      end
      SERVICE: begin
        if (complete_req && (complete_id == active_id)) begin
          state_nxt  = IDLE;
          active_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state         <= IDLE;
      prev_irq      <= '0;
      pending       <= '0;
      enable        <= '0;
      thresh        <= '0;
      best_valid    <= 1'b0;
      best_id       <= '0;
      active_id     <= '0;
      claim_valid   <= 1'b0;
      claim_id      <= '0;
      ext_int_clear <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
    end else begin
      state         <= state_nxt;
      prev_irq      <= src_irq;
      pending       <= pending_nxt;
      best_valid    <= arb_valid;
      best_id       <= arb_id;
      active_id     <= active_nxt;
      claim_valid   <= claim_valid_nxt;
      claim_id      <= claim_id_nxt;
      ext_int_clear <= ext_int_clear_nxt;
      if (en_wen) enable <= en_wdata;
      if (thresh_wen) thresh <= thresh_wdata;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (prio_wen && (prio_idx == ID_W'(i + 1))) prio[i] <= prio_wdata;
      end
    end
  end

  assign ext_int = (state == ASSERT);

endmodule
`default_nettype wire

// File: tb/tb_priv_1_11_ext_int_ctrl.sv
`default_nettype none
// =============================================================================
// tb_priv_1_11_ext_int_ctrl: vector table, directed sequences and randomized
// stimulus against a behavioural model. Revision: 1.0
// =============================================================================
module tb_priv_1_11_ext_int_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] src_irq;
  logic       en_wen;
  logic [7:0] en_wdata;
  logic       prio_wen;
  logic [3:0] prio_idx;
  logic [2:0] prio_wdata;
  logic       thresh_wen;
  logic [2:0] thresh_wdata;
  logic       claim_req;
  logic       claim_valid;
  logic [3:0] claim_id;
  logic       complete_req;
  logic [3:0] complete_id;
  logic       ext_int;
  logic       ext_int_clear;

  always #5 CLK = ~CLK;

  priv_1_11_ext_int_ctrl #(.NUM_SRC(8), .PRIO_W(3), .ID_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .src_irq(src_irq),
    .en_wen(en_wen), .en_wdata(en_wdata),
    .prio_wen(prio_wen), .prio_idx(prio_idx), .prio_wdata(prio_wdata),
    .thresh_wen(thresh_wen), .thresh_wdata(thresh_wdata),
    .claim_req(claim_req), .claim_valid(claim_valid), .claim_id(claim_id),
    .complete_req(complete_req), .complete_id(complete_id),
    .ext_int(ext_int), .ext_int_clear(ext_int_clear)
  );

  typedef struct {
    logic [7:0] irq;
    logic       en_w;
    logic [7:0] en_d;
    logic       pr_w;
    logic [3:0] idx;
    logic [2:0] pr_d;
    logic       th_w;
    logic [2:0] th_d;
    logic       claim;
    logic       comp;
    logic [3:0] cid;
  } stim_t;

  typedef struct {
    stim_t s;
    int    ext;
    int    clr;
    int    cv;
    int    id;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: spec-level state (mode 0 idle, 1 asserting, 2 in service).
  logic [7:0] m_prev, m_pend, m_en;
  int m_prio[9];
  int m_thr, m_bid, m_mode, m_active, m_cid;
  bit m_bv, m_clr, m_cv;

  function automatic stim_t nop();
    stim_t s;
    s.irq = '0; s.en_w = 0; s.en_d = '0; s.pr_w = 0; s.idx = '0; s.pr_d = '0;
    s.th_w = 0; s.th_d = '0; s.claim = 0; s.comp = 0; s.cid = '0;
    return s;
  endfunction

  function automatic stim_t s_irq(logic [7:0] v);
    stim_t s = nop(); s.irq = v; return s;
  endfunction
  function automatic stim_t s_en(logic [7:0] v);
    stim_t s = nop(); s.en_w = 1; s.en_d = v; return s;
  endfunction
  function automatic stim_t s_prio(int id, int v);
    stim_t s = nop(); s.pr_w = 1; s.idx = 4'(id); s.pr_d = 3'(v); return s;
  endfunction
  function automatic stim_t s_thr(int v);
    stim_t s = nop(); s.th_w = 1; s.th_d = 3'(v); return s;
  endfunction
  function automatic stim_t s_claim();
    stim_t s = nop(); s.claim = 1; return s;
  endfunction
  function automatic stim_t s_comp(int id);
    stim_t s = nop(); s.comp = 1; s.cid = 4'(id); return s;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_en = '0;
    for (int i = 0; i < 9; i++) m_prio[i] = 0;
    m_thr = 0; m_bv = 0; m_bid = 0; m_mode = 0; m_active = 0;
    m_clr = 0; m_cv = 0; m_cid = 0;
  endtask

  task automatic model_step(input stim_t s);
    int old_mode = m_mode;
    int old_active = m_active;
    bit old_bv = m_bv;
    int old_bid = m_bid;
    int claimed = 0;
    int best = 0;
    int best_score = -1;
    // Winner = maximum of (priority, reversed ID) among eligible sources.
    for (int id = 1; id <= 8; id++) begin
      if (m_pend[id-1] && m_en[id-1] && m_prio[id] > m_thr) begin
        if (m_prio[id] * 16 + (15 - id) > best_score) begin
          best_score = m_prio[id] * 16 + (15 - id);
          best = id;
        end
      end
    end
    m_cv = s.claim; m_cid = 0; m_clr = 0;
    if (old_mode == 1 && s.claim && old_bv) begin
      claimed = old_bid; m_cid = old_bid; m_clr = 1; m_mode = 2; m_active = old_bid;
    end else if (old_mode == 1 && !old_bv) begin
      m_mode = 0; m_clr = 1;
    end else if (old_mode == 0 && old_bv) begin
      m_mode = 1;
    end else if (old_mode == 2 && s.comp && int'(s.cid) == old_active) begin
      m_mode = 0; m_active = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (s.irq[i] && !m_prev[i] && !(old_mode == 2 && old_active == i + 1) && claimed != i + 1)
        m_pend[i] = 1'b1;
      if (claimed == i + 1) m_pend[i] = 1'b0;
    end
    if (s.en_w) m_en = s.en_d;
    if (s.pr_w && s.idx >= 1 && s.idx <= 8) m_prio[int'(s.idx)] = int'(s.pr_d);
    if (s.th_w) m_thr = int'(s.th_d);
    m_prev = s.irq;
    m_bv = (best != 0);
    m_bid = best;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    src_irq = s.irq; en_wen = s.en_w; en_wdata = s.en_d;
    prio_wen = s.pr_w; prio_idx = s.idx; prio_wdata = s.pr_d;
    thresh_wen = s.th_w; thresh_wdata = s.th_d;
    claim_req = s.claim; complete_req = s.comp; complete_id = s.cid;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare #1 later.
  task automatic step(input stim_t s);
    drive(s);
    @(posedge CLK);
    model_step(s);
    #1;
    check("model ext_int", int'(ext_int), int'(m_mode == 1));
    check("model ext_int_clear", int'(ext_int_clear), int'(m_clr));
    check("model claim_valid", int'(claim_valid), int'(m_cv));
    check("model claim_id", int'(claim_id), m_cid);
  endtask

  task automatic wait_ext(input string name);
    int n = 0;
    while (ext_int !== 1'b1 && n < 12) begin
      step(nop());
      n++;
    end
    check(name, int'(ext_int), 1);
  endtask

  task automatic do_reset();
    drive(nop());
    nRST = 1'b1;
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int order[3];
    logic [7:0] lvl;

    nRST = 1'b1;
    drive(nop());
    model_reset();
    @(posedge CLK);
    #1;
    check("reset ext_int", int'(ext_int), 0);
    check("reset ext_int_clear", int'(ext_int_clear), 0);
    check("reset claim_valid", int'(claim_valid), 0);
    check("reset claim_id", int'(claim_id), 0);
    @(posedge CLK);
    #1;
    nRST = 1'b0;

    // Basic flow: expected outputs observed just after each edge.
    tbl[0]  = '{s_en(8'hFF),   0, 0, 0, 0};
    tbl[1]  = '{s_prio(3, 5),  0, 0, 0, 0};
    tbl[2]  = '{s_thr(0),      0, 0, 0, 0};
    tbl[3]  = '{s_irq(8'h04),  0, 0, 0, 0};
    tbl[4]  = '{nop(),         0, 0, 0, 0};
    tbl[5]  = '{nop(),         1, 0, 0, 0};
    tbl[6]  = '{nop(),         1, 0, 0, 0};
    tbl[7]  = '{s_claim(),     0, 1, 1, 3};
    tbl[8]  = '{nop(),         0, 0, 0, 0};
    tbl[9]  = '{s_comp(3),     0, 0, 0, 0};
    tbl[10] = '{s_claim(),     0, 0, 1, 0};
    tbl[11] = '{nop(),         0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].s);
      check($sformatf("vec%0d ext_int", i), int'(ext_int), tbl[i].ext);
      check($sformatf("vec%0d ext_int_clear", i), int'(ext_int_clear), tbl[i].clr);
      check($sformatf("vec%0d claim_valid", i), int'(claim_valid), tbl[i].cv);
      check($sformatf("vec%0d claim_id", i), int'(claim_id), tbl[i].id);
    end

    // Priority with a tie between IDs 5 and 7.
    step(s_prio(2, 4));
    step(s_prio(5, 6));
    step(s_prio(7, 6));
    step(s_irq(8'h52));
    order = '{5, 7, 2};
    for (int k = 0; k < 3; k++) begin
      wait_ext($sformatf("prio ext_int before claim %0d", k));
      step(s_claim());
      check($sformatf("prio claim %0d id", k), int'(claim_id), order[k]);
      step(s_comp(order[k]));
    end

    // Threshold masking and disable while asserting.
    step(s_prio(4, 3));
    step(s_thr(3));
    step(s_irq(8'h08));
    for (int k = 0; k < 6; k++) begin
      step(nop());
      check("thresh equal blocks", int'(ext_int), 0);
    end
    step(s_thr(2));
    wait_ext("thresh lowered");
    step(s_en(8'hF7));
    begin
      int n = 0;
      while (ext_int_clear !== 1'b1 && n < 6) begin
        step(nop());
        n++;
      end
      check("disable clear pulse", int'(ext_int_clear), 1);
      check("disable ext_int low", int'(ext_int), 0);
    end
    step(nop());
    check("clear pulse one cycle", int'(ext_int_clear), 0);
    step(s_prio(4, 0));
    step(s_en(8'hFF));

    // Null claim in service and mismatched complete.
    step(s_irq(8'h04));
    wait_ext("null ext_int");
    step(s_claim());
    check("null claim id 3", int'(claim_id), 3);
    step(s_comp(4));
    step(s_claim());
    check("service claim valid", int'(claim_valid), 1);
    check("service claim id 0", int'(claim_id), 0);
    step(s_comp(3));
    step(nop());

    // Edge on the in-service source is dropped.
    step(s_thr(0));
    step(s_prio(1, 2));
    step(s_irq(8'h01));
    wait_ext("in-service ext_int");
    step(s_claim());
    check("in-service claim id 1", int'(claim_id), 1);
    step(s_irq(8'h01));
    step(nop());
    step(s_comp(1));
    for (int k = 0; k < 6; k++) begin
      step(nop());
      check("dropped edge no ext_int", int'(ext_int), 0);
    end

    // Asynchronous reset during a claim response.
    step(s_irq(8'h04));
    wait_ext("pre-reset ext_int");
    step(s_claim());
    check("pre-reset claim_valid", int'(claim_valid), 1);
    nRST = 1'b1;
    #1;
    check("async reset claim_valid", int'(claim_valid), 0);
    check("async reset claim_id", int'(claim_id), 0);
    check("async reset ext_int_clear", int'(ext_int_clear), 0);
    check("async reset ext_int", int'(ext_int), 0);
    do_reset();
    step(s_en(8'hFF));
    step(s_irq(8'h04));
    for (int k = 0; k < 6; k++) begin
      step(nop());
      check("post-reset prio 0 silent", int'(ext_int), 0);
    end
    step(s_prio(3, 5));
    wait_ext("post-reset reprogrammed");

    // Randomized traffic against the model.
    do_reset();
    lvl = '0;
    for (int c = 0; c < 3000; c++) begin
      stim_t s = nop();
      if ($urandom_range(0, 3) == 0) lvl = lvl ^ (8'h01 << $urandom_range(0, 7));
      s.irq = lvl;
      if ($urandom_range(0, 19) == 0) begin s.en_w = 1; s.en_d = 8'($urandom); end
      if ($urandom_range(0, 9) == 0) begin
        s.pr_w = 1; s.idx = 4'($urandom_range(0, 15)); s.pr_d = 3'($urandom);
      end
      if ($urandom_range(0, 24) == 0) begin s.th_w = 1; s.th_d = 3'($urandom_range(0, 4)); end
      s.claim = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 4) == 0) begin
        s.comp = 1;
        s.cid = ($urandom_range(0, 9) < 7) ? 4'(m_active) : 4'($urandom_range(0, 9));
      end
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
